// File: rtl/jt08_adpcmb_pkg.sv
// Shared ADPCM-B definitions: address width, access-port state encoding and
// the address-advance rule used by both this port and the playback counter.
package jt08_adpcmb_pkg;

  localparam int ADPCMB_AW = 21;

  typedef logic [ADPCMB_AW-1:0] baddr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_CPU,
    ST_MEM_WR,
    ST_MEM_RD,
    ST_DONE
  } wr_state_t;

  // Address that follows addr. The end of region is tested before the limit,
  // so a region ending exactly at the limit returns to astart, not to zero.
  function automatic baddr_t adv_addr(baddr_t addr, baddr_t astart,
                                      baddr_t aend, baddr_t alimit);
    if (addr == aend)
      return astart;
    else if (addr == alimit)
      return '0;
    else
      return addr + 1'b1;
  endfunction

endpackage

// File: rtl/jt08_adpcmb_wr_if.sv
// Memory-side bus of the ADPCM-B CPU access port: request held until a
// one-cycle ack; read data is valid together with the ack.
interface jt08_adpcmb_wr_if #(
  parameter int AW = 21
);
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_req;
  logic          mem_wr;
  logic          mem_ack;
  logic [7:0]    mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_req, mem_wr,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_req, mem_wr,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/jt08_adpcmb_astep.sv
// Combinational next-address unit with end/limit compares. AW must equal
// ADPCMB_AW because the shared advance function works at that width.
module jt08_adpcmb_astep
  import jt08_adpcmb_pkg::*;
#(
  parameter int AW = ADPCMB_AW
) (
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] astart,
  input  logic [AW-1:0] aend,
  input  logic [AW-1:0] alimit,
  output logic [AW-1:0] next_addr,
  output logic          at_end,
  output logic          at_limit
);

  assign at_end    = (addr == aend);
  assign at_limit  = (addr == alimit);
  assign next_addr = adv_addr(addr, astart, aend, alimit);

endmodule

// File: rtl/jt08_adpcmb_wr.sv
// CPU-side ADPCM-B memory access port: moves bytes between the CPU data
// register and sample memory, paced by BRDY towards the CPU and req/ack
// towards memory, raising a sticky flag when the region end is reached.
module jt08_adpcmb_wr
  import jt08_adpcmb_pkg::*;
#(
  parameter int AW = ADPCMB_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          start,
  input  logic          rd_mode,
  input  logic          arepeat,
  input  logic [AW-1:0] astart,
  input  logic [AW-1:0] aend,
  input  logic [AW-1:0] alimit,
  input  logic          din_we,
  input  logic [7:0]    din,
  input  logic          dout_re,
  output logic [7:0]    dout,
  output logic          brdy,
  output logic          busy,
  output logic          flag,
  input  logic          clr_flag,
  jt08_adpcmb_wr_if.master mem
);

  wr_state_t     state_reg;
  logic [AW-1:0] addr_reg;
  logic          rd_mode_reg;
  logic          brdy_reg;
  logic          flag_reg;
  logic          req_reg;
  logic          wr_reg;
  logic [7:0]    dout_reg;
  logic [7:0]    wdata_reg;

  logic [AW-1:0] next_addr;
  logic          at_end;
  logic          at_limit_unused;  // the limit is folded into next_addr already
  logic          cpu_read;
  logic          wr_done;
  logic          keep_going;

  jt08_adpcmb_astep #(.AW(AW)) u_astep (
    .addr      (addr_reg),
    .astart    (astart),
    .aend      (aend),
    .alimit    (alimit),
    .next_addr (next_addr),
    .at_end    (at_end),
    .at_limit  (at_limit_unused)
  );

  // A byte is consumed either when the CPU reads it or when memory acks a write.
  assign cpu_read   = (state_reg == ST_WAIT_CPU) && rd_mode_reg && dout_re && brdy_reg;
  assign wr_done    = (state_reg == ST_MEM_WR) && mem.mem_ack;
  assign keep_going = !at_end || arepeat;

  // Session state machine; clr beats start, start beats everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      rd_mode_reg <= 1'b0;
      brdy_reg    <= 1'b0;
      flag_reg    <= 1'b0;
      req_reg     <= 1'b0;
      wr_reg      <= 1'b0;
      dout_reg    <= 8'h00;
      wdata_reg   <= 8'h00;
    end else begin
      // Clearing first lets a same-cycle end-of-region set win below.
      if (clr_flag)
        flag_reg <= 1'b0;

      if (clr) begin
        state_reg <= ST_IDLE;
        brdy_reg  <= 1'b0;
        req_reg   <= 1'b0;
      end else if (start) begin
        addr_reg    <= astart;
        rd_mode_reg <= rd_mode;
        if (rd_mode) begin
          // Prefetch the first byte so it is waiting when the CPU reads.
          state_reg <= ST_MEM_RD;
          brdy_reg  <= 1'b0;
          req_reg   <= 1'b1;
          wr_reg    <= 1'b0;
        end else begin
          state_reg <= ST_WAIT_CPU;
          brdy_reg  <= 1'b1;
          req_reg   <= 1'b0;
        end
      end else begin
        case (state_reg)
          ST_WAIT_CPU: begin
            if (!rd_mode_reg && din_we && brdy_reg) begin
              wdata_reg <= din;
              brdy_reg  <= 1'b0;
              req_reg   <= 1'b1;
              wr_reg    <= 1'b1;
              state_reg <= ST_MEM_WR;
            end
          end
          ST_MEM_RD: begin
            if (mem.mem_ack) begin
              dout_reg  <= mem.mem_rdata;
              brdy_reg  <= 1'b1;
              req_reg   <= 1'b0;
              state_reg <= ST_WAIT_CPU;
            end
          end
          default: ;
        endcase

        if (cpu_read || wr_done) begin
          req_reg  <= 1'b0;
          brdy_reg <= 1'b0;
          if (at_end)
            flag_reg <= 1'b1;
          if (keep_going) begin
            addr_reg <= next_addr;
            if (rd_mode_reg) begin
              state_reg <= ST_MEM_RD;
              req_reg   <= 1'b1;
              wr_reg    <= 1'b0;
            end else begin
              state_reg <= ST_WAIT_CPU;
              brdy_reg  <= 1'b1;
            end
          end else begin
            state_reg <= ST_DONE;
          end
        end
      end
    end
  end

  assign dout          = dout_reg;
  assign brdy          = brdy_reg;
  assign flag          = flag_reg;
  assign busy          = (state_reg == ST_WAIT_CPU) || (state_reg == ST_MEM_WR) ||
                         (state_reg == ST_MEM_RD);
  assign mem.mem_addr  = addr_reg;
  assign mem.mem_wdata = wdata_reg;
  assign mem.mem_req   = req_reg;
  assign mem.mem_wr    = wr_reg;

endmodule
